s641_scan_state: RTL and testbench

S641_SCAN_STATE -- requirements
Module: s641_scan_state

---
 rtl/s641_pkg.sv | 22 ++
 rtl/s641_state_reg.sv | 39 +++
 rtl/s641_scan_state.sv | 92 +++++++++
 tb/tb_s641_scan_state.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/s641_pkg.sv
// Shared constants and types for the s641 scan-state wrapper.
package s641_pkg;

  localparam int NSTATE    = 19;
  localparam int SHIFT_LEN = 19;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Operation applied to the present-state register on the next clock edge.
  typedef enum logic [1:0] {
    PS_HOLD  = 2'd0,
    PS_LOAD  = 2'd1,
    PS_SHIFT = 2'd2
  } ps_op_e;

endpackage

// File: rtl/s641_state_reg.sv
// Present-state register with load / shift-right / hold mux; 1-cycle latency.
// No backpressure: the selected operation is applied on every rising clock edge.
module s641_state_reg
  import s641_pkg::*;
#(
  parameter int W = NSTATE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  ps_op_e       op,
  input  logic [W-1:0] ns,
  input  logic         scan_in,
  output logic [W-1:0] ps
);

  logic [W-1:0] ps_d;
  logic [W-1:0] ps_q;

  // Shifting moves toward bit 0, so the LSB is always the next bit to unload.
  always_comb begin
    ps_d = ps_q;
    case (op)
      PS_LOAD:  ps_d = ns;
      PS_SHIFT: ps_d = {scan_in, ps_q[W-1:1]};
      default:  ps_d = ps_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign ps = ps_q;

endmodule

// File: rtl/s641_scan_state.sv
// s641 state register with scan unload/load FSM; NS->PS 1 cycle when functional.
// No backpressure: once started, a scan operation runs to completion and ignores inputs.
module s641_scan_state #(
  parameter int NSTATE = s641_pkg::NSTATE
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic [NSTATE-1:0] NS,
  output logic [NSTATE-1:0] PS,
  input  logic              FUNC_EN,
  input  logic              SCAN_REQ,
  input  logic              SCAN_IN,
  output logic              SCAN_OUT,
  output logic              SCAN_BUSY,
  output logic              SCAN_DONE,
  input  logic              SCAN_CAPT
);

  import s641_pkg::*;

  state_e             state_d;
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   cnt_q;
  ps_op_e             ps_op;
  logic [NSTATE-1:0]  ps;

  // Requests are only looked at in IDLE; DONE always falls back to IDLE first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ps_op   = PS_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (SCAN_REQ) begin
          state_d = SCAN_CAPT ? ST_CAPT : ST_SHIFT;
          cnt_d   = '0;
        end else if (FUNC_EN) begin
          ps_op = PS_LOAD;
        end
      end
      ST_CAPT: begin
        ps_op   = PS_LOAD;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        ps_op = PS_SHIFT;
        if (cnt_q == CNT_W'(SHIFT_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  s641_state_reg #(
    .W (NSTATE)
  ) u_state_reg (
    .clk     (CK),
    .rst_n   (RSTN),
    .op      (ps_op),
    .ns      (NS),
    .scan_in (SCAN_IN),
    .ps      (ps)
  );

  assign PS        = ps;
  assign SCAN_OUT  = ps[0];
  assign SCAN_BUSY = (state_q != ST_IDLE);
  assign SCAN_DONE = (state_q == ST_DONE);

endmodule

// File: tb/tb_s641_scan_state.sv
// Self-checking bench for s641_scan_state: vector table plus scan sequences, scoreboard-checked.
module tb_s641_scan_state;

  localparam int W = 19;

  logic          CK = 1'b0;
  logic          RSTN;
  logic [W-1:0]  NS;
  logic [W-1:0]  PS;
  logic          FUNC_EN;
  logic          SCAN_REQ;
  logic          SCAN_IN;
  logic          SCAN_OUT;
  logic          SCAN_BUSY;
  logic          SCAN_DONE;
  logic          SCAN_CAPT;

  typedef struct {
    logic [W-1:0] ps;
    logic         busy;
    logic         done;
    logic         sout;
  } exp_t;

  typedef struct {
    logic         rstn;
    logic         fe;
    logic         req;
    logic         capt;
    logic         sin;
    logic [W-1:0] ns;
    logic [W-1:0] e_ps;
    logic         e_busy;
    logic         e_done;
  } vec_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] ps_model;

  s641_scan_state #(.NSTATE(W)) dut (
    .CK        (CK),
    .RSTN      (RSTN),
    .NS        (NS),
    .PS        (PS),
    .FUNC_EN   (FUNC_EN),
    .SCAN_REQ  (SCAN_REQ),
    .SCAN_IN   (SCAN_IN),
    .SCAN_OUT  (SCAN_OUT),
    .SCAN_BUSY (SCAN_BUSY),
    .SCAN_DONE (SCAN_DONE),
    .SCAN_CAPT (SCAN_CAPT)
  );

  always #5 CK = ~CK;

  // Each entry pushed at a falling edge describes the outputs after the next rising edge.
  always @(posedge CK) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      if (PS !== e.ps) begin
        n_err++;
        $display("FAIL ps vec %0d: got %05h want %05h", n_vec, PS, e.ps);
      end
      if (SCAN_BUSY !== e.busy) begin
        n_err++;
        $display("FAIL busy vec %0d: got %b want %b", n_vec, SCAN_BUSY, e.busy);
      end
      if (SCAN_DONE !== e.done) begin
        n_err++;
        $display("FAIL done vec %0d: got %b want %b", n_vec, SCAN_DONE, e.done);
      end
      if (SCAN_OUT !== e.sout) begin
        n_err++;
        $display("FAIL scan_out vec %0d: got %b want %b", n_vec, SCAN_OUT, e.sout);
      end
    end
  end

  task automatic cyc(input logic rstn, input logic fe, input logic req, input logic capt,
                     input logic sin, input logic [W-1:0] ns, input logic [W-1:0] e_ps,
                     input logic e_busy, input logic e_done);
    exp_t e;
    @(negedge CK);
    RSTN      = rstn;
    FUNC_EN   = fe;
    SCAN_REQ  = req;
    SCAN_CAPT = capt;
    SCAN_IN   = sin;
    NS        = ns;
    e.ps   = e_ps;
    e.busy = e_busy;
    e.done = e_done;
    e.sout = e_ps[0];
    sb.push_back(e);
    ps_model = e_ps;
  endtask

  // One full scan operation; bits[j] is the j-th SCAN_IN bit shifted in.
  task automatic scan_op(input logic capt, input logic [W-1:0] ns_v, input logic [W-1:0] bits,
                         input logic fe_noise, input logic hold);
    logic [W-1:0] m;
    m = ps_model;
    // FUNC_EN high with a different NS: the request must win and PS must not load.
    cyc(1'b1, 1'b1, 1'b1, capt, 1'b0, ns_v ^ 19'h00001, m, 1'b1, 1'b0);
    if (capt) begin
      m = ns_v;
      cyc(1'b1, fe_noise, hold, hold, 1'b0, ns_v, m, 1'b1, 1'b0);
    end
    for (int j = 0; j < W; j++) begin
      m = {bits[j], m[W-1:1]};
      cyc(1'b1, fe_noise && (j % 2 == 0), hold, hold, bits[j], 19'h55555 ^ 19'(j),
          m, 1'b1, (j == W - 1));
    end
    cyc(1'b1, 1'b0, hold, hold, 1'b0, 19'h00000, m, 1'b0, 1'b0);
  endtask

  initial begin
    vec_t tbl[7];
    logic [W-1:0] m;

    RSTN = 1'b0; FUNC_EN = 1'b0; SCAN_REQ = 1'b0; SCAN_IN = 1'b0;
    SCAN_CAPT = 1'b0; NS = '0; ps_model = '0;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'h7FFFF, 19'h00000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h5A5A5, 19'h5A5A5, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 19'h00001, 19'h5A5A5, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h12345, 19'h12345, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h00000, 19'h12345, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 19'h7FFFF, 19'h7FFFF, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h2AAAA, 19'h7FFFF, 1'b0, 1'b0};

    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'h00000, 19'h00000, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].rstn, tbl[i].fe, tbl[i].req, tbl[i].capt, tbl[i].sin, tbl[i].ns,
          tbl[i].e_ps, tbl[i].e_busy, tbl[i].e_done);
    end

    // All-ones unload with zeros in: nineteen 1s out, PS ends at 0.
    scan_op(1'b0, 19'h2AAAA, 19'h00000, 1'b0, 1'b0);
    // Capture 3 then unload: 1,1 then zeros.
    scan_op(1'b1, 19'h00003, 19'h00000, 1'b0, 1'b0);
    // Single leading 1 lands in PS[0]; FUNC_EN pulses during shift are ignored.
    scan_op(1'b0, 19'h7FFFF, 19'h00001, 1'b1, 1'b0);
    scan_op(1'b1, 19'h4B3C1, 19'h2D0F6, 1'b1, 1'b0);
    // SCAN_REQ held high: DONE, one IDLE cycle, then the next operation.
    scan_op(1'b0, 19'h11111, 19'h3C3C3, 1'b0, 1'b1);
    scan_op(1'b0, 19'h22222, 19'h0F0F0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h00000, ps_model, 1'b0, 1'b0);

    // Reset during shift cycle 7 aborts without a done pulse.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h6DB6D, 19'h6DB6D, 1'b0, 1'b0);
    m = 19'h6DB6D;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 19'h00000, m, 1'b1, 1'b0);
    for (int j = 0; j < 7; j++) begin
      m = {1'b1, m[W-1:1]};
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 19'h00000, m, 1'b1, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'h7FFFF, 19'h00000, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h01234, 19'h00000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0ABCD, 19'h0ABCD, 1'b0, 1'b0);

    // A request seen only while in reset must not survive it.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'h7FFFF, 19'h00000, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 19'h33333, 19'h33333, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'h44444, 19'h33333, 1'b0, 1'b0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge CK);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
